// File: rtl/int_to_float.sv
// int_to_float: multi-cycle signed 32-bit integer to IEEE-754 single converter.
// Valid/ready on both sides; one operand in flight at a time.
// Optional macro INT_TO_FLOAT_FAST_NORM_EN selects a single-cycle
// leading-zero-count + barrel-shift normalizer instead of the default
// one-bit-per-cycle normalizer. Results are identical either way.
module int_to_float (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op,
  input  logic [1:0]  rmode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        inexact
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic signed [31:0] op_q;
  logic [1:0]         rmode_q;
  logic               sign_q;
  logic [31:0]        mag_q;
  logic [7:0]         exp_q;

  // Rounding increment for the 2-bit FPU rounding-mode encoding.
  function automatic logic round_inc(input logic [1:0] rm, input logic s,
                                     input logic g, input logic st,
                                     input logic lsb);
    logic r;
    case (rm)
      2'd0:    r = g & (st | lsb);
      2'd1:    r = 1'b0;
      2'd2:    r = ~s & (g | st);
      default: r = s & (g | st);
    endcase
    return r;
  endfunction

`ifdef INT_TO_FLOAT_FAST_NORM_EN
  // Leading-zero count; only used on a nonzero magnitude, so 5 bits suffice.
  function automatic logic [4:0] lead_zeros(input logic [31:0] v);
    logic [4:0] lz;
    logic       found;
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lz = lz + 5'd1;
      end
    end
    return lz;
  endfunction

  logic [4:0] norm_lz;
  assign norm_lz = lead_zeros(mag_q);
`endif

  logic [31:0] abs_mag;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        rnd_inx;
  logic        rnd_inc;
  logic [23:0] mant_sum;
  logic [7:0]  exp_rnd;
  logic [31:0] rnd_res;

  // 0x80000000 negates to itself, which read unsigned is the wanted 2^31.
  assign abs_mag  = op_q[31] ? $unsigned(-op_q) : $unsigned(op_q);

  assign mant     = mag_q[30:8];
  assign guard    = mag_q[7];
  assign sticky   = |mag_q[6:0];
  assign rnd_inx  = guard | sticky;
  assign rnd_inc  = round_inc(rmode_q, sign_q, guard, sticky, mant[0]);
  assign mant_sum = {1'b0, mant} + {23'd0, rnd_inc};
  // A mantissa carry-out leaves mant_sum[22:0] all zero and bumps the exponent;
  // the exponent tops out at 159, so no overflow to infinity is possible.
  assign exp_rnd  = exp_q + {7'd0, mant_sum[23]};
  assign rnd_res  = {sign_q, exp_rnd, mant_sum[22:0]};

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state and handshake decode from the registered state.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_ABS;
      end
      // A zero operand still passes through ROUND, which yields +0 exactly.
      S_ABS: state_nx = (abs_mag == 32'd0) ? S_ROUND : S_NORM;
      S_NORM: begin
`ifdef INT_TO_FLOAT_FAST_NORM_EN
        state_nx = S_ROUND;
`else
        if (mag_q[31]) state_nx = S_ROUND;
`endif
      end
      S_ROUND: state_nx = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: capture operand, take magnitude, normalize, round into res.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      rmode_q <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      res     <= '0;
      inexact <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= op;
            rmode_q <= rmode;
          end
        end
        S_ABS: begin
          sign_q <= op_q[31];
          mag_q  <= abs_mag;
          exp_q  <= (abs_mag == 32'd0) ? 8'd0 : 8'd158;
        end
        S_NORM: begin
`ifdef INT_TO_FLOAT_FAST_NORM_EN
          mag_q <= mag_q << norm_lz;
          exp_q <= exp_q - {3'd0, norm_lz};
`else
          if (!mag_q[31]) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 8'd1;
          end
`endif
        end
        S_ROUND: begin
          res     <= rnd_res;
          inexact <= rnd_inx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// tb_int_to_float: table-driven and random checks of int_to_float with a
// scoreboard queue, plus reset-mid-conversion and backpressure sequences.
module tb_int_to_float;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op;
  logic [1:0]  rmode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        inexact;

  int total = 0;
  int bad   = 0;

  logic [32:0] sb[$];

  typedef struct {
    logic [31:0] op;
    logic [1:0]  rm;
    logic [31:0] res;
    logic        inx;
  } vec_t;

  vec_t tbl[13];

  int_to_float dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rmode     (rmode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .inexact   (inexact)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference conversion: locate the MSB, truncate, then round from the
  // discarded remainder compared against one half ulp.
  function automatic logic [32:0] model(input logic [31:0] v, input logic [1:0] rm);
    logic        s;
    logic [63:0] m, q, rem, half;
    logic        inx, inc;
    int          p, sh;
    logic [7:0]  e;
    s = v[31];
    m = {32'd0, (s ? (~v + 32'd1) : v)};
    if (m == 64'd0) return 33'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    inx = 1'b0;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      case (rm)
        2'd0:    inc = (rem > half) || ((rem == half) && q[0]);
        2'd1:    inc = 1'b0;
        2'd2:    inc = !s && inx;
        default: inc = s && inx;
      endcase
      q = q + {63'd0, inc};
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    e = 8'(127 + p);
    return {inx, s, e, q[22:0]};
  endfunction

  function automatic int exp_latency(input logic [31:0] v);
    logic [31:0] m;
    int lz;
    if (v == 32'd0) return 2;
`ifdef INT_TO_FLOAT_FAST_NORM_EN
    return 3;
`else
    m  = v[31] ? (~v + 32'd1) : v;
    lz = 0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) break;
      lz++;
    end
    return 3 + lz;
`endif
  endfunction

  // Offer one operand, push its expectation, wait for the result, compare,
  // optionally stall in DONE for 'hold' cycles, then hand the result off.
  task automatic convert(input logic [31:0] v, input logic [1:0] rm,
                         input logic [31:0] eres, input logic einx, input int hold);
    int lat;
    logic [32:0] got;
    logic [31:0] held;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    sb.push_back({einx, eres});
    in_valid = 1'b1;
    op       = v;
    rmode    = rm;
    @(posedge clock); #1;
    in_valid = 1'b0;
    op       = ~v;
    rmode    = ~rm;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", lat, exp_latency(v));
    got = sb.pop_front();
    chk("res", res, got[31:0]);
    chk("inexact", {31'd0, inexact}, {31'd0, got[32]});
    held = res;
    if (hold > 0) begin
      in_valid = 1'b1;
      op       = 32'd5;
      for (int k = 0; k < hold; k++) begin
        @(posedge clock); #1;
        chk("bp_res_stable", res, held);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      end
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("after_hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("after_hs_in_ready", {31'd0, in_ready}, 32'd1);
    if (hold > 0) begin
      @(posedge clock); #1;
      chk("bp_not_accepted", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [32:0] m;
    logic [31:0] r;

    tbl[0]  = '{32'h00000001, 2'd0, 32'h3F800000, 1'b0};
    tbl[1]  = '{32'hFFFFFFFF, 2'd0, 32'hBF800000, 1'b0};
    tbl[2]  = '{32'h00000000, 2'd0, 32'h00000000, 1'b0};
    tbl[3]  = '{32'h80000000, 2'd0, 32'hCF000000, 1'b0};
    tbl[4]  = '{32'h7FFFFFFF, 2'd0, 32'h4F000000, 1'b1};
    tbl[5]  = '{32'h7FFFFFFF, 2'd1, 32'h4EFFFFFF, 1'b1};
    tbl[6]  = '{32'h7FFFFFFF, 2'd3, 32'h4EFFFFFF, 1'b1};
    tbl[7]  = '{32'h7FFFFFFF, 2'd2, 32'h4F000000, 1'b1};
    tbl[8]  = '{32'h01000001, 2'd0, 32'h4B800000, 1'b1};
    tbl[9]  = '{32'h01000001, 2'd2, 32'h4B800001, 1'b1};
    tbl[10] = '{32'hFEFFFFFF, 2'd3, 32'hCB800001, 1'b1};
    tbl[11] = '{32'h01000003, 2'd0, 32'h4B800002, 1'b1};
    tbl[12] = '{32'h00000003, 2'd1, 32'h40400000, 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    rmode     = '0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_res", res, 32'd0);
    chk("rst_inexact", {31'd0, inexact}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 13; i++)
      convert(tbl[i].op, tbl[i].rm, tbl[i].res, tbl[i].inx, 0);

    // Reset in the middle of a conversion; res is nonzero beforehand.
    in_valid = 1'b1;
    op       = 32'd1;
    rmode    = 2'd0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #2;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_res", res, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) begin
      @(posedge clock); #1;
      chk("midrst_no_output", {31'd0, out_valid}, 32'd0);
    end
    convert(32'd2, 2'd0, 32'h40000000, 1'b0, 0);

    // Random operands of varied magnitude against the reference model.
    for (int i = 0; i < 24; i++) begin
      r = $urandom() >> $urandom_range(31, 0);
      if ($urandom_range(1, 0) == 1) r = ~r + 32'd1;
      rmode = 2'($urandom_range(3, 0));
      m = model(r, rmode);
      convert(r, rmode, m[31:0], m[32], 0);
    end

    // Backpressure: stall in DONE for ten cycles with an operand offered.
    m = model(32'h12345678, 2'd2);
    convert(32'h12345678, 2'd2, m[31:0], m[32], 10);
    convert(32'hFFFFFF80, 2'd0, 32'hC3000000, 1'b0, 0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
